slave_bus_host_loader: RTL and testbench

- Synthesizable host-side initiator for the accelerator's slave RAM port (the S_oe_ram/S_we_ram/S_addr_ram/S_Wdata_ram/S_data_ram_size request side and the Sout_Rdata_ram/Sout_DataRdy response side).
- Preloads accelerator memory from a byte stream, pulses start_port and waits for done_port while counting cycles.
- Reads back a result window and streams it out.
- Replaces the testbench's tied-off slave drive in FPGA bring-up and hardware-in-the-loop runs.

---
 rtl/slave_bus_host_pkg.sv | 31 +++
 rtl/slave_access_ch.sv | 63 ++++++
 rtl/slave_bus_host_loader.sv | 262 ++++++++++++++++++++++++++
 tb/tb_slave_bus_host_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_bus_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slave_bus_host_pkg
//  Description : Shared state encoding, error codes and access size for the
//                slave-bus host loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package slave_bus_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_REQ  = 4'd1,
    ST_LOAD_WAIT = 4'd2,
    ST_START     = 4'd3,
    ST_RUN       = 4'd4,
    ST_READ_REQ  = 4'd5,
    ST_READ_WAIT = 4'd6,
    ST_OUT       = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  localparam logic [1:0] c_ERR_NONE = 2'd0;
  localparam logic [1:0] c_ERR_LOAD = 2'd1;
  localparam logic [1:0] c_ERR_RUN  = 2'd2;
  localparam logic [1:0] c_ERR_READ = 2'd3;

  // Every access is a single byte
  localparam int BYTE_SIZE = 8;

endpackage
`default_nettype wire

// File: rtl/slave_access_ch.sv
`default_nettype none
// ============================================================================
//  Module      : slave_access_ch
//  Description : Single-channel slave RAM request driver. Presents one
//                read or write while i_req is high, reports completion on
//                DataRdy and flags a timeout after XFER_LIMIT wait cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_access_ch
  import slave_bus_host_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int SIZE_W     = 4,
  parameter int XFER_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_is_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rdy,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_timeout,
  output logic              o_oe,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [SIZE_W-1:0] o_size
);

  localparam int c_WAIT_W = $clog2(XFER_LIMIT + 1);

  logic [c_WAIT_W-1:0] r_wait;
  logic                w_last_wait;

  // Wait counter restarts whenever no request is outstanding
  always_ff @(posedge clk) begin
    if (rst || !i_req) begin
      r_wait <= '0;
    end else if (!w_last_wait) begin
      r_wait <= r_wait + c_WAIT_W'(1);
    end
  end

  assign w_last_wait = (r_wait == c_WAIT_W'(XFER_LIMIT - 1));

  // DataRdy only counts while a request is on the bus
  assign o_ack     = i_req & i_rdy;
  assign o_timeout = i_req & ~i_rdy & w_last_wait;
  assign o_rdata   = i_rdata;

  assign o_we    = i_req & i_is_write;
  assign o_oe    = i_req & ~i_is_write;
  assign o_addr  = i_req ? i_addr : '0;
  assign o_wdata = (i_req && i_is_write) ? i_wdata : '0;
  assign o_size  = i_req ? SIZE_W'(BYTE_SIZE) : '0;

endmodule
`default_nettype wire

// File: rtl/slave_bus_host_loader.sv
`default_nettype none
// ============================================================================
//  Module      : slave_bus_host_loader
//  Description : Host-side initiator for the accelerator slave RAM port.
//                Loads a byte stream, pulses start_port, times the run and
//                streams a result window back out.
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_bus_host_loader
  import slave_bus_host_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int SIZE_W     = 4,
  parameter int LEN_W      = 8,
  parameter int XFER_LIMIT = 64,
  parameter int RUN_LIMIT  = 200000000,
  parameter int CNT_W      = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_go,
  input  logic [ADDR_W-1:0]          cfg_load_addr,
  input  logic [LEN_W-1:0]           cfg_load_len,
  input  logic [ADDR_W-1:0]          cfg_rd_addr,
  input  logic [LEN_W-1:0]           cfg_rd_len,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS-1:0]        S_oe_ram,
  output logic [CHANNELS-1:0]        S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0] S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0] S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0] S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]        Sout_DataRdy,
  output logic                       start_port,
  input  logic                       done_port,
  output logic                       busy,
  output logic                       finished,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [CNT_W-1:0]           cycle_count
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_rd_len;
  logic              r_req;
  logic              r_is_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_start;
  logic              r_finished;
  logic              r_busy;
  logic              r_error;
  logic [1:0]        r_err_code;
  logic [CNT_W-1:0]  r_cycle_count;

  logic              w_ack;
  logic              w_timeout;
  logic [DATA_W-1:0] w_rdata;
  logic              w_oe;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [SIZE_W-1:0] w_size;
  logic              w_unused;

  slave_access_ch #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SIZE_W     (SIZE_W),
    .XFER_LIMIT (XFER_LIMIT)
  ) u_ch0 (
    .clk        (clock),
    .rst        (reset),
    .i_req      (r_req),
    .i_is_write (r_is_write),
    .i_addr     (r_addr),
    .i_wdata    (r_wdata),
    .i_rdy      (Sout_DataRdy[0]),
    .i_rdata    (Sout_Rdata_ram[DATA_W-1:0]),
    .o_ack      (w_ack),
    .o_rdata    (w_rdata),
    .o_timeout  (w_timeout),
    .o_oe       (w_oe),
    .o_we       (w_we),
    .o_addr     (w_addr),
    .o_wdata    (w_wdata),
    .o_size     (w_size)
  );

  // Channel 0 is the only active lane; upper channels zero-extend to 0
  assign S_oe_ram        = CHANNELS'(w_oe);
  assign S_we_ram        = CHANNELS'(w_we);
  assign S_addr_ram      = (CHANNELS*ADDR_W)'(w_addr);
  assign S_Wdata_ram     = (CHANNELS*DATA_W)'(w_wdata);
  assign S_data_ram_size = (CHANNELS*SIZE_W)'(w_size);
  assign w_unused        = &{1'b0, Sout_DataRdy, Sout_Rdata_ram};

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign start_port  = r_start;
  assign finished    = r_finished;
  assign busy        = r_busy;
  assign error       = r_error;
  assign err_code    = r_err_code;
  assign cycle_count = r_cycle_count;

  // Sequencer: load -> start -> run -> readback, every output flag registered
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_rd_addr     <= '0;
      r_rd_len      <= '0;
      r_req         <= 1'b0;
      r_is_write    <= 1'b0;
      r_wdata       <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_start       <= 1'b0;
      r_finished    <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= c_ERR_NONE;
      r_cycle_count <= '0;
    end else begin
      r_start    <= 1'b0;
      r_finished <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_go) begin
            r_addr        <= cfg_load_addr;
            r_len         <= cfg_load_len;
            r_rd_addr     <= cfg_rd_addr;
            r_rd_len      <= cfg_rd_len;
            r_error       <= 1'b0;
            r_err_code    <= c_ERR_NONE;
            r_cycle_count <= '0;
            r_busy        <= 1'b1;
            if (cfg_load_len != '0) begin
              r_state    <= ST_LOAD_REQ;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= ST_START;
              r_start <= 1'b1;
            end
          end
        end
        ST_LOAD_REQ: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_req      <= 1'b1;
            r_is_write <= 1'b1;
            r_wdata    <= in_data;
            r_state    <= ST_LOAD_WAIT;
          end
        end
        ST_LOAD_WAIT: begin
          if (w_ack) begin
            r_req  <= 1'b0;
            r_addr <= r_addr + ADDR_W'(1);
            r_len  <= r_len - LEN_W'(1);
            if (r_len == LEN_W'(1)) begin
              r_state <= ST_START;
              r_start <= 1'b1;
            end else begin
              r_state    <= ST_LOAD_REQ;
              r_in_ready <= 1'b1;
            end
          end else if (w_timeout) begin
            r_req      <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= c_ERR_LOAD;
            r_finished <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_START: begin
          r_cycle_count <= CNT_W'(1);
          r_state       <= ST_RUN;
        end
        ST_RUN: begin
          r_cycle_count <= r_cycle_count + CNT_W'(1);
          if (done_port) begin
            r_addr <= r_rd_addr;
            r_len  <= r_rd_len;
            if (r_rd_len != '0) begin
              r_state <= ST_READ_REQ;
            end else begin
              r_finished <= 1'b1;
              r_state    <= ST_DONE;
            end
          end else if (r_cycle_count == CNT_W'(RUN_LIMIT - 1)) begin
            r_error    <= 1'b1;
            r_err_code <= c_ERR_RUN;
            r_finished <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_READ_REQ: begin
          r_req      <= 1'b1;
          r_is_write <= 1'b0;
          r_state    <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          if (w_ack) begin
            r_req       <= 1'b0;
            r_out_data  <= w_rdata;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else if (w_timeout) begin
            r_req      <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= c_ERR_READ;
            r_finished <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_addr      <= r_addr + ADDR_W'(1);
            r_len       <= r_len - LEN_W'(1);
            if (r_len == LEN_W'(1)) begin
              r_finished <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_state <= ST_READ_REQ;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_req       <= 1'b0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slave_bus_host_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slave_bus_host_loader
//  Description : Directed self-checking bench for slave_bus_host_loader with
//                a behavioural slave RAM responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_bus_host_loader;

  localparam int CHANNELS   = 2;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int SIZE_W     = 4;
  localparam int LEN_W      = 8;
  localparam int XFER_LIMIT = 64;
  localparam int RUN_LIMIT  = 100;
  localparam int CNT_W      = 32;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic                       cmd_go = 1'b0;
  logic [ADDR_W-1:0]          cfg_load_addr = '0;
  logic [LEN_W-1:0]           cfg_load_len = '0;
  logic [ADDR_W-1:0]          cfg_rd_addr = '0;
  logic [LEN_W-1:0]           cfg_rd_len = '0;
  logic [DATA_W-1:0]          in_data = '0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [DATA_W-1:0]          out_data;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [CHANNELS-1:0]        S_oe_ram;
  logic [CHANNELS-1:0]        S_we_ram;
  logic [CHANNELS*ADDR_W-1:0] S_addr_ram;
  logic [CHANNELS*DATA_W-1:0] S_Wdata_ram;
  logic [CHANNELS*SIZE_W-1:0] S_data_ram_size;
  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram;
  logic [CHANNELS-1:0]        Sout_DataRdy;
  logic                       start_port;
  logic                       done_port = 1'b0;
  logic                       busy;
  logic                       finished;
  logic                       error;
  logic [1:0]                 err_code;
  logic [CNT_W-1:0]           cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  slave_bus_host_loader #(
    .CHANNELS (CHANNELS), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .SIZE_W (SIZE_W),
    .LEN_W (LEN_W), .XFER_LIMIT (XFER_LIMIT), .RUN_LIMIT (RUN_LIMIT), .CNT_W (CNT_W)
  ) dut (
    .clock (clock), .reset (reset), .cmd_go (cmd_go),
    .cfg_load_addr (cfg_load_addr), .cfg_load_len (cfg_load_len),
    .cfg_rd_addr (cfg_rd_addr), .cfg_rd_len (cfg_rd_len),
    .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
    .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
    .S_oe_ram (S_oe_ram), .S_we_ram (S_we_ram), .S_addr_ram (S_addr_ram),
    .S_Wdata_ram (S_Wdata_ram), .S_data_ram_size (S_data_ram_size),
    .Sout_Rdata_ram (Sout_Rdata_ram), .Sout_DataRdy (Sout_DataRdy),
    .start_port (start_port), .done_port (done_port), .busy (busy),
    .finished (finished), .error (error), .err_code (err_code),
    .cycle_count (cycle_count)
  );

  initial forever #5 clock = ~clock;

  // Slave RAM model: answers rsp_delay cycles into a request; bit 1 of
  // DataRdy is held high and the upper read byte is junk to catch misuse.
  logic [7:0] mem [0:127];
  bit         rsp_en = 1'b1;
  int         rsp_delay = 1;
  int         rsp_cnt = 0;
  int         n_start = 0;
  int         n_fin = 0;
  logic [6:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [6:0] rd_addr_q [$];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    Sout_DataRdy   = 2'b10;
    Sout_Rdata_ram = 16'hEE00;
    forever begin
      @(negedge clock);
      if (start_port) n_start++;
      if (finished) n_fin++;
      if (S_we_ram[0] || S_oe_ram[0]) begin
        rsp_cnt++;
        if (rsp_en && rsp_cnt > rsp_delay && !Sout_DataRdy[0]) begin
          Sout_DataRdy = 2'b11;
          if (S_we_ram[0]) begin
            mem[S_addr_ram[6:0]] = S_Wdata_ram[7:0];
            wr_addr_q.push_back(S_addr_ram[6:0]);
            wr_data_q.push_back(S_Wdata_ram[7:0]);
          end else begin
            Sout_Rdata_ram = {8'hEE, mem[S_addr_ram[6:0]]};
            rd_addr_q.push_back(S_addr_ram[6:0]);
          end
        end
      end else begin
        rsp_cnt      = 0;
        Sout_DataRdy = 2'b10;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  // Bounded poll at negedges; an expired bound counts as a failed comparison
  task automatic wait_for(input int which, input int limit, input string what, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      case (which)
        0: ok = in_ready;
        1: ok = start_port;
        2: ok = out_valid;
        3: ok = finished;
        default: ok = S_oe_ram[0];
      endcase
      if (ok) break;
      @(negedge clock);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_%s: still 0 after %0d cycles, required 1", what, limit);
    end
  endtask

  task automatic go();
    @(negedge clock);
    cmd_go = 1'b1;
    @(negedge clock);
    cmd_go = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    wait_for(0, 200, "in_ready", ok);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({busy, finished, error, err_code, start_port, in_ready, out_valid} !== 8'h00) begin
      n_bad++; $display("FAIL reset_flags: got %b, required 00000000",
                        {busy, finished, error, err_code, start_port, in_ready, out_valid});
    end
    n_cmp++;
    if (cycle_count !== 32'd0 || out_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_data: count %0d data %h, required 0 00", cycle_count, out_data);
    end
    n_cmp++;
    if ({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size} !== '0) begin
      n_bad++; $display("FAIL reset_bus: oe %b we %b addr %h size %h, required all 0",
                        S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load_run();
    bit ok;
    logic [7:0] bytes [3];
    bytes = '{8'hA1, 8'hB2, 8'hC3};
    rsp_en = 1'b1; rsp_delay = 1;
    wr_addr_q.delete(); wr_data_q.delete();
    n_start = 0; n_fin = 0;
    cfg_load_addr = 7'h10; cfg_load_len = 8'd3; cfg_rd_addr = 7'h00; cfg_rd_len = 8'd0;
    go();
    for (int i = 0; i < 3; i++) send_byte(bytes[i]);
    wait_for(1, 100, "start_port", ok);
    repeat (5) @(negedge clock);
    done_port = 1'b1;
    @(negedge clock);
    done_port = 1'b0;
    n_cmp++;
    if (finished !== 1'b1 || cycle_count !== 32'd6 || error !== 1'b0) begin
      n_bad++; $display("FAIL run_count: finished %b count %0d error %b, required 1 6 0",
                        finished, cycle_count, error);
    end
    @(negedge clock);
    n_cmp++;
    if (n_start !== 1 || n_fin !== 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL load_pulses: start %0d finished %0d busy %b, required 1 1 0",
                        n_start, n_fin, busy);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wr_addr_q.size() != 3 || wr_addr_q[i] !== 7'(7'h10 + i) || wr_data_q[i] !== bytes[i]) begin
        n_bad++; $display("FAIL load_write%0d: %0d writes, addr %h data %h, required addr %h data %h",
                          i, wr_addr_q.size(), wr_addr_q[i], wr_data_q[i], 7'(7'h10 + i), bytes[i]);
      end
    end
  endtask

  task automatic test_readback();
    bit ok;
    bit stable;
    logic [7:0] d0;
    logic [7:0] exp_b [3];
    logic [6:0] exp_a [3];
    exp_b = '{8'h11, 8'h22, 8'h33};
    exp_a = '{7'h7E, 7'h7F, 7'h00};
    mem[7'h7E] = 8'h11; mem[7'h7F] = 8'h22; mem[7'h00] = 8'h33;
    rd_addr_q.delete();
    cfg_load_len = 8'd0; cfg_rd_addr = 7'h7E; cfg_rd_len = 8'd3;
    go();
    wait_for(1, 20, "start_port", ok);
    @(negedge clock);
    done_port = 1'b1;
    @(negedge clock);
    done_port = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_for(2, 200, "out_valid", ok);
      d0 = out_data;
      stable = 1'b1;
      repeat (4) begin
        @(negedge clock);
        if (out_data !== d0 || out_valid !== 1'b1) stable = 1'b0;
      end
      n_cmp++;
      if (d0 !== exp_b[i] || !stable) begin
        n_bad++; $display("FAIL read_byte%0d: data %h stable %b, required %h stable 1",
                          i, d0, stable, exp_b[i]);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
    end
    wait_for(3, 20, "finished", ok);
    n_cmp++;
    if (cycle_count !== 32'd2 || error !== 1'b0) begin
      n_bad++; $display("FAIL read_count: count %0d error %b, required 2 0", cycle_count, error);
    end
    n_cmp++;
    if (rd_addr_q.size() != 3 || rd_addr_q[0] !== exp_a[0] || rd_addr_q[1] !== exp_a[1] ||
        rd_addr_q[2] !== exp_a[2]) begin
      n_bad++; $display("FAIL read_addrs: %0d reads last %h, required 3 reads 7e 7f 00",
                        rd_addr_q.size(), rd_addr_q[2]);
    end
    @(negedge clock);
  endtask

  task automatic test_load_timeout();
    int wcnt;
    int start_before;
    rsp_en = 1'b0;
    start_before = n_start;
    cfg_load_addr = 7'h20; cfg_load_len = 8'd2; cfg_rd_len = 8'd0;
    go();
    send_byte(8'h5A);
    wcnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!S_we_ram[0]) break;
      wcnt++;
      @(negedge clock);
    end
    n_cmp++;
    if (wcnt !== XFER_LIMIT) begin
      n_bad++; $display("FAIL load_to_len: we high %0d cycles, required %0d", wcnt, XFER_LIMIT);
    end
    n_cmp++;
    if (finished !== 1'b1 || error !== 1'b1 || err_code !== 2'd1) begin
      n_bad++; $display("FAIL load_to_err: finished %b error %b code %0d, required 1 1 1",
                        finished, error, err_code);
    end
    @(negedge clock);
    n_cmp++;
    if (n_start !== start_before || busy !== 1'b0) begin
      n_bad++; $display("FAIL load_to_nostart: starts %0d busy %b, required %0d 0",
                        n_start, busy, start_before);
    end
    rsp_en = 1'b1;
  endtask

  task automatic test_run_timeout();
    bit ok;
    cfg_load_len = 8'd0; cfg_rd_len = 8'd0;
    go();
    n_cmp++;
    if (error !== 1'b0 || err_code !== 2'd0) begin
      n_bad++; $display("FAIL err_clear: error %b code %0d, required 0 0", error, err_code);
    end
    wait_for(3, 300, "finished", ok);
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd2 || cycle_count !== 32'd100) begin
      n_bad++; $display("FAIL run_to: error %b code %0d count %0d, required 1 2 100",
                        error, err_code, cycle_count);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    rsp_en = 1'b0;
    cfg_load_len = 8'd0; cfg_rd_addr = 7'h05; cfg_rd_len = 8'd2;
    go();
    wait_for(1, 20, "start_port", ok);
    @(negedge clock);
    cfg_rd_len = 8'd0; cfg_rd_addr = 7'h40;
    cmd_go = 1'b1;
    @(negedge clock);
    cmd_go = 1'b0;
    done_port = 1'b1;
    @(negedge clock);
    done_port = 1'b0;
    wait_for(4, 10, "oe", ok);
    n_cmp++;
    if (S_oe_ram !== 2'b01 || S_addr_ram !== 14'h0005 || S_data_ram_size !== 8'h08 || busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_go: oe %b addr %h size %h busy %b, required 01 0005 08 1",
                        S_oe_ram, S_addr_ram, S_data_ram_size, busy);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, busy, out_valid, in_ready,
         finished, error, start_port} !== '0 || cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL mid_reset: oe %b addr %h busy %b count %0d, required all 0",
                        S_oe_ram, S_addr_ram, busy, cycle_count);
    end
    reset = 1'b0;
    rsp_en = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp_b [2];
    exp_b = '{8'h5C, 8'h6D};
    rsp_delay = 0;
    wr_addr_q.delete(); wr_data_q.delete();
    cfg_load_addr = 7'h7F; cfg_load_len = 8'd2; cfg_rd_addr = 7'h7F; cfg_rd_len = 8'd2;
    go();
    send_byte(exp_b[0]);
    send_byte(exp_b[1]);
    wait_for(1, 50, "start_port", ok);
    @(negedge clock);
    done_port = 1'b1;
    @(negedge clock);
    done_port = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_for(2, 50, "out_valid", ok);
      n_cmp++;
      if (out_data !== exp_b[i]) begin
        n_bad++; $display("FAIL b2b_byte%0d: data %h, required %h", i, out_data, exp_b[i]);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
    end
    n_cmp++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 7'h7F || wr_addr_q[1] !== 7'h00) begin
      n_bad++; $display("FAIL b2b_wrap: %0d writes last addr %h, required 2 ending 00",
                        wr_addr_q.size(), wr_addr_q[1]);
    end
    wait_for(3, 20, "finished", ok);
    @(negedge clock);
    rsp_delay = 1;
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_readback();
    test_load_timeout();
    test_run_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
